// File: rtl/enigma_cipher_sequencer.sv
// Command sequencer for the Enigma core: decodes byte commands into rotor/plug
// config writes, then steps the rotors and walks the nine substitution passes.
module enigma_cipher_sequencer #(
  parameter int NSTAGE = 9,
  parameter int ALPHA  = 26
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_op_i,
  input  logic [4:0] cmd_arg_i,
  output logic       cfg_we_o,
  output logic [1:0] cfg_rotor_o,
  output logic [1:0] cfg_field_o,
  output logic [4:0] cfg_data_o,
  output logic       plug_we_o,
  output logic [4:0] plug_a_o,
  output logic [4:0] plug_b_o,
  output logic [2:0] step_en_o,
  input  logic       notch_r_i,
  input  logic       notch_m_i,
  output logic       sub_req_o,
  output logic [3:0] sub_stage_o,
  output logic [4:0] sub_in_o,
  input  logic       sub_ack_i,
  input  logic [4:0] sub_out_i,
  output logic       out_valid_o,
  output logic [4:0] out_char_o,
  output logic       err_o
);

  localparam logic [2:0] OP_SEL   = 3'd1;
  localparam logic [2:0] OP_TYPE  = 3'd2;
  localparam logic [2:0] OP_START = 3'd3;
  localparam logic [2:0] OP_RING  = 3'd4;
  localparam logic [2:0] OP_PLUGA = 3'd5;
  localparam logic [2:0] OP_PLUGB = 3'd6;
  localparam logic [2:0] OP_ENC   = 3'd7;
  localparam logic [4:0] LAST_LETTER = 5'(ALPHA - 1);
  localparam logic [3:0] LAST_STAGE  = 4'(NSTAGE - 1);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_STEP, S_SUB, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_rotor_q, sel_rotor_d;
  logic [4:0] plug_a_q, plug_a_d;
  logic [4:0] data_q, data_d;
  logic [1:0] field_q, field_d;
  logic       is_plug_q, is_plug_d;
  logic [4:0] sub_in_q, sub_in_d;
  logic [3:0] stage_q, stage_d;
  logic [4:0] out_char_q, out_char_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;
  logic       letter_ok;

  assign letter_ok = (cmd_arg_i <= LAST_LETTER);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sel_rotor_q <= '0;
      plug_a_q    <= '0;
      data_q      <= '0;
      field_q     <= '0;
      is_plug_q   <= 1'b0;
      sub_in_q    <= '0;
      stage_q     <= '0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_rotor_q <= sel_rotor_d;
      plug_a_q    <= plug_a_d;
      data_q      <= data_d;
      field_q     <= field_d;
      is_plug_q   <= is_plug_d;
      sub_in_q    <= sub_in_d;
      stage_q     <= stage_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_rotor_d = sel_rotor_q;
    plug_a_d    = plug_a_q;
    data_d      = data_q;
    field_d     = field_q;
    is_plug_d   = is_plug_q;
    sub_in_d    = sub_in_q;
    stage_d     = stage_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    cmd_ready_o = 1'b0;
    cfg_we_o    = 1'b0;
    plug_we_o   = 1'b0;
    step_en_o   = 3'b000;
    sub_req_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          out_valid_d = 1'b0;
          case (cmd_op_i)
            OP_SEL: sel_rotor_d = cmd_arg_i[1:0];
            OP_TYPE: begin
              if (cmd_arg_i > 5'd7) err_d = 1'b1;
              else begin
                field_d   = 2'd0;
                data_d    = cmd_arg_i;
                is_plug_d = 1'b0;
                state_d   = S_CFG;
              end
            end
            OP_START, OP_RING: begin
              if (!letter_ok) err_d = 1'b1;
              else begin
                field_d   = (cmd_op_i == OP_START) ? 2'd1 : 2'd2;
                data_d    = cmd_arg_i;
                is_plug_d = 1'b0;
                state_d   = S_CFG;
              end
            end
            OP_PLUGA: begin
              if (!letter_ok) err_d = 1'b1;
              else plug_a_d = cmd_arg_i;
            end
            OP_PLUGB: begin
              // A letter cannot be plugged to itself.
              if (!letter_ok || cmd_arg_i == plug_a_q) err_d = 1'b1;
              else begin
                data_d    = cmd_arg_i;
                is_plug_d = 1'b1;
                state_d   = S_CFG;
              end
            end
            OP_ENC: begin
              if (!letter_ok) err_d = 1'b1;
              else begin
                sub_in_d = cmd_arg_i;
                stage_d  = '0;
                state_d  = S_STEP;
              end
            end
            default: ;
          endcase
        end
      end
      S_CFG: begin
        cfg_we_o  = ~is_plug_q;
        plug_we_o = is_plug_q;
        state_d   = S_IDLE;
      end
      S_STEP: begin
        // Middle rotor also steps when it sits on its own notch (double-step).
        step_en_o = {notch_m_i, notch_r_i | notch_m_i, 1'b1};
        stage_d   = '0;
        state_d   = S_SUB;
      end
      S_SUB: begin
        sub_req_o = 1'b1;
        if (sub_ack_i) begin
          sub_in_d = sub_out_i;
          if (stage_q == LAST_STAGE) begin
            out_char_d  = sub_out_i;
            out_valid_d = 1'b1;
            stage_d     = '0;
            state_d     = S_DONE;
          end else begin
            stage_d = stage_q + 4'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst_i) begin
      cfg_we_o  = 1'b0;
      plug_we_o = 1'b0;
      step_en_o = 3'b000;
    end
  end

  assign cfg_rotor_o = cfg_we_o ? sel_rotor_q : 2'd0;
  assign cfg_field_o = cfg_we_o ? field_q : 2'd0;
  assign cfg_data_o  = cfg_we_o ? data_q : 5'd0;
  assign plug_a_o    = plug_we_o ? plug_a_q : 5'd0;
  assign plug_b_o    = plug_we_o ? data_q : 5'd0;
  assign sub_stage_o = stage_q;
  assign sub_in_o    = sub_in_q;
  assign out_valid_o = out_valid_q;
  assign out_char_o  = out_char_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_enigma_cipher_sequencer.sv
// Bench for enigma_cipher_sequencer: directed scenarios plus randomized encrypts
// against a pass-by-pass lookup model of the substitution datapath.
module tb_enigma_cipher_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [4:0] cmd_arg = '0;
  logic       cfg_we;
  logic [1:0] cfg_rotor, cfg_field;
  logic [4:0] cfg_data;
  logic       plug_we;
  logic [4:0] plug_a, plug_b;
  logic [2:0] step_en;
  logic       notch_r = 1'b0, notch_m = 1'b0;
  logic       sub_req;
  logic [3:0] sub_stage;
  logic [4:0] sub_in;
  logic       sub_ack;
  logic [4:0] sub_out;
  logic       out_valid;
  logic [4:0] out_char;
  logic       err;

  int errors = 0;
  int checks = 0;

  logic [4:0] lut [0:15][0:31];
  int stall_stage = -1;
  int stall_n = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  assign sub_out = lut[sub_stage][sub_in];
  assign sub_ack = sub_req && ((int'(sub_stage) != stall_stage) || (wait_cnt >= stall_n));

  always @(posedge clk) begin
    if (sub_req && !sub_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  enigma_cipher_sequencer dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg), .cfg_we_o(cfg_we), .cfg_rotor_o(cfg_rotor),
    .cfg_field_o(cfg_field), .cfg_data_o(cfg_data), .plug_we_o(plug_we),
    .plug_a_o(plug_a), .plug_b_o(plug_b), .step_en_o(step_en), .notch_r_i(notch_r),
    .notch_m_i(notch_m), .sub_req_o(sub_req), .sub_stage_o(sub_stage), .sub_in_o(sub_in),
    .sub_ack_i(sub_ack), .sub_out_i(sub_out), .out_valid_o(out_valid),
    .out_char_o(out_char), .err_o(err)
  );

  task automatic fill_lut(input bit rnd);
    for (int s = 0; s < 16; s++)
      for (int x = 0; x < 32; x++)
        lut[s][x] = rnd ? 5'($urandom_range(0, 25)) : 5'((x + 1) % 26);
  endtask

  function automatic logic [4:0] model(input logic [4:0] c);
    logic [4:0] v = c;
    for (int s = 0; s < 9; s++) v = lut[s][v];
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for ready, presents one command for one accept cycle.
  task automatic send_cmd(input logic [2:0] op, input logic [4:0] arg);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL send_ready: cmd_ready=%b expected 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Runs one encrypt and records what the DUT did; comparisons are done by callers.
  task automatic do_encrypt(input logic [4:0] c, input logic nr, input logic nm,
                            output int lat, output logic [2:0] step_or,
                            output int step_cycles, output int seq_bad,
                            output logic [4:0] och);
    int exp_stage = 0;
    logic [4:0] cur = c;
    lat = -1; step_or = '0; step_cycles = 0; seq_bad = 0;
    notch_r = nr; notch_m = nm;
    send_cmd(3'd7, c);
    for (int n = 1; n <= 60; n++) begin
      if (step_en != 3'b000) begin step_or |= step_en; step_cycles++; end
      if (sub_req) begin
        if (int'(sub_stage) != exp_stage || sub_in !== cur) seq_bad++;
        if (sub_ack) begin cur = lut[exp_stage][cur]; exp_stage++; end
      end
      if (cmd_ready && out_valid) begin lat = n; break; end
      @(negedge clk);
    end
    och = out_char;
    notch_r = 1'b0; notch_m = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    if (sub_req !== 1'b0) begin errors++; $display("FAIL reset_subreq: got %b want 0", sub_req); end
    if (step_en !== 3'b000) begin errors++; $display("FAIL reset_step: got %b want 000", step_en); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b want 0", out_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_config();
    send_cmd(3'd1, 5'd1);
    send_cmd(3'd3, 5'd4);
    checks += 5;
    if (cfg_we !== 1'b1) begin errors++; $display("FAIL cfg_we: got %b want 1", cfg_we); end
    if (cfg_rotor !== 2'd1) begin errors++; $display("FAIL cfg_rotor: got %0d want 1", cfg_rotor); end
    if (cfg_field !== 2'd1) begin errors++; $display("FAIL cfg_field: got %0d want 1", cfg_field); end
    if (cfg_data !== 5'd4) begin errors++; $display("FAIL cfg_data: got %0d want 4", cfg_data); end
    if (err !== 1'b0) begin errors++; $display("FAIL cfg_err: got %b want 0", err); end
    @(negedge clk);
    checks++;
    if (cfg_we !== 1'b0) begin errors++; $display("FAIL cfg_we_pulse: got %b want 0", cfg_we); end
    send_cmd(3'd4, 5'd9);
    checks++;
    if (cfg_field !== 2'd2 || cfg_data !== 5'd9) begin
      errors++; $display("FAIL cfg_ring: field=%0d data=%0d want 2/9", cfg_field, cfg_data);
    end
  endtask

  task automatic test_encrypt();
    int lat, sc, bad; logic [2:0] so; logic [4:0] oc;
    fill_lut(1'b0); stall_stage = -1; stall_n = 0;
    do_encrypt(5'd0, 1'b0, 1'b0, lat, so, sc, bad, oc);
    checks += 5;
    if (oc !== 5'd9) begin errors++; $display("FAIL enc0_char: got %0d want 9", oc); end
    if (lat != 12) begin errors++; $display("FAIL enc0_latency: got %0d want 12", lat); end
    if (so !== 3'b001 || sc != 1) begin errors++; $display("FAIL enc0_step: got %b x%0d want 001 x1", so, sc); end
    if (bad != 0) begin errors++; $display("FAIL enc0_seq: got %0d bad passes want 0", bad); end
    if (err !== 1'b0) begin errors++; $display("FAIL enc0_err: got %b want 0", err); end
    do_encrypt(5'd20, 1'b0, 1'b0, lat, so, sc, bad, oc);
    checks++;
    if (oc !== 5'd3) begin errors++; $display("FAIL enc20_wrap: got %0d want 3", oc); end
    send_cmd(3'd0, 5'd0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL outvalid_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_double_step();
    int lat, sc, bad; logic [2:0] so; logic [4:0] oc;
    do_encrypt(5'd5, 1'b0, 1'b1, lat, so, sc, bad, oc);
    checks++;
    if (so !== 3'b111 || sc != 1) begin errors++; $display("FAIL dstep_m: got %b x%0d want 111 x1", so, sc); end
    do_encrypt(5'd5, 1'b1, 1'b0, lat, so, sc, bad, oc);
    checks++;
    if (so !== 3'b011 || sc != 1) begin errors++; $display("FAIL dstep_r: got %b x%0d want 011 x1", so, sc); end
  endtask

  task automatic test_errors();
    int seen_step = 0, seen_req = 0, seen_plug = 0;
    do_reset();
    send_cmd(3'd7, 5'd26);
    for (int n = 0; n < 15; n++) begin
      if (step_en != 3'b000) seen_step++;
      if (sub_req) seen_req++;
      @(negedge clk);
    end
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL enc26_err: got %b want 1", err); end
    if (seen_step != 0) begin errors++; $display("FAIL enc26_step: got %0d pulses want 0", seen_step); end
    if (seen_req != 0) begin errors++; $display("FAIL enc26_req: got %0d cycles want 0", seen_req); end
    do_reset();
    send_cmd(3'd2, 5'd8);
    checks++;
    if (err !== 1'b1 || cfg_we !== 1'b0) begin errors++; $display("FAIL type8: err=%b cfg_we=%b want 1/0", err, cfg_we); end
    do_reset();
    send_cmd(3'd5, 5'd3);
    send_cmd(3'd6, 5'd3);
    for (int n = 0; n < 4; n++) begin if (plug_we) seen_plug++; @(negedge clk); end
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL plug_same_err: got %b want 1", err); end
    if (seen_plug != 0) begin errors++; $display("FAIL plug_same_we: got %0d pulses want 0", seen_plug); end
    do_reset();
    send_cmd(3'd5, 5'd3);
    send_cmd(3'd6, 5'd7);
    checks += 2;
    if (plug_we !== 1'b1 || plug_a !== 5'd3 || plug_b !== 5'd7) begin
      errors++; $display("FAIL plug_pair: we=%b a=%0d b=%0d want 1/3/7", plug_we, plug_a, plug_b);
    end
    if (err !== 1'b0) begin errors++; $display("FAIL plug_pair_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    int lat, sc, bad; logic [2:0] so; logic [4:0] oc;
    fill_lut(1'b0); stall_stage = 4; stall_n = 3;
    do_encrypt(5'd0, 1'b0, 1'b0, lat, so, sc, bad, oc);
    checks += 3;
    if (lat != 15) begin errors++; $display("FAIL stall_latency: got %0d want 15", lat); end
    if (bad != 0) begin errors++; $display("FAIL stall_stable: got %0d bad cycles want 0", bad); end
    if (oc !== 5'd9) begin errors++; $display("FAIL stall_char: got %0d want 9", oc); end
    stall_stage = -1; stall_n = 0;
  endtask

  task automatic test_reset_midop();
    int n = 0, late_pulses = 0;
    send_cmd(3'd7, 5'd2);
    while (!(sub_req && sub_stage == 4'd5) && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!(sub_req && sub_stage == 4'd5)) begin errors++; $display("FAIL midop_reach: stage=%0d req=%b want 5/1", sub_stage, sub_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (sub_req !== 1'b0) begin errors++; $display("FAIL midop_req: got %b want 0", sub_req); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midop_idle: got %b want 1", cmd_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_outvalid: got %b want 0", out_valid); end
    for (int k = 0; k < 15; k++) begin
      if (step_en != 3'b000 || cfg_we || plug_we || sub_req) late_pulses++;
      @(negedge clk);
    end
    checks++;
    if (late_pulses != 0) begin errors++; $display("FAIL midop_quiet: got %0d active cycles want 0", late_pulses); end
  endtask

  task automatic test_random();
    int lat, sc, bad; logic [2:0] so; logic [4:0] oc, c, exp_c; logic nr, nm;
    fill_lut(1'b1);
    for (int it = 0; it < 20; it++) begin
      c = 5'($urandom_range(0, 25));
      nr = 1'($urandom); nm = 1'($urandom);
      stall_stage = $urandom_range(0, 8); stall_n = $urandom_range(0, 3);
      exp_c = model(c);
      do_encrypt(c, nr, nm, lat, so, sc, bad, oc);
      checks += 4;
      if (oc !== exp_c) begin errors++; $display("FAIL rnd_char[%0d]: got %0d want %0d", it, oc, exp_c); end
      if (lat != 12 + stall_n) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, lat, 12 + stall_n); end
      if (so !== {nm, nr | nm, 1'b1} || sc != 1) begin
        errors++; $display("FAIL rnd_step[%0d]: got %b x%0d want %b x1", it, so, sc, {nm, nr | nm, 1'b1});
      end
      if (bad != 0) begin errors++; $display("FAIL rnd_seq[%0d]: got %0d bad cycles want 0", it, bad); end
    end
    stall_stage = -1; stall_n = 0;
  endtask

  initial begin
    fill_lut(1'b0);
    test_reset();
    test_config();
    test_encrypt();
    test_double_step();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
